weight_ram_writer: RTL and testbench



---
 rtl/weight_pkg.sv | 19 +
 rtl/weight_row_packer.sv | 43 ++++
 rtl/weight_ram_writer.sv | 144 ++++++++++++++
 tb/tb_weight_ram_writer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_pkg.sv
// Shared constants, writer state encoding and row addressing helper for the weight RAM writer.
package weight_pkg;

   localparam int unsigned WEIGHT_W  = 10;
   localparam int unsigned ROW_WORDS = 10;
   localparam int unsigned NUM_ROWS  = 10;
   localparam int unsigned WADDR_W   = 7;
   localparam int unsigned ROW_BITS  = ROW_WORDS * WEIGHT_W;
   localparam int unsigned CNT_W     = $clog2(ROW_WORDS);
   localparam int unsigned ROW_IDX_W = $clog2(NUM_ROWS);

   typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} writer_state_e;

   // NUM_ROWS*ROW_WORDS fits in WADDR_W bits, so the truncation never drops set bits.
   function automatic logic [WADDR_W-1:0] row_base(input logic [ROW_IDX_W-1:0] row_idx);
      return WADDR_W'(32'(row_idx) * ROW_WORDS);
   endfunction

endpackage

// File: rtl/weight_row_packer.sv
// Collects accepted weight words into a row buffer. o_row is the buffer with the incoming
// word already merged, so the word that completes a row can be captured on the same edge.
module weight_row_packer
   import weight_pkg::*;
(
   input  logic                Clock,
   input  logic                Rst,
   input  logic                i_clear,
   input  logic                i_accept,
   input  logic [WEIGHT_W-1:0] i_word,
   output logic                o_last,
   output logic [ROW_BITS-1:0] o_row
);

   logic [CNT_W-1:0]    r_word_cnt;
   logic [ROW_BITS-1:0] r_row;
   logic                w_row_full;

   always_comb begin
      w_row_full = (r_word_cnt == CNT_W'(ROW_WORDS - 1));
      o_last     = i_accept && w_row_full;
      o_row      = r_row;
      for (int k = 0; k < ROW_WORDS; k++) begin
         if (r_word_cnt == CNT_W'(k)) begin
            o_row[k*WEIGHT_W +: WEIGHT_W] = i_word;
         end
      end
   end

   // Stale slots from the previous row are harmless: every slot is rewritten before the next write.
   always_ff @(posedge Clock) begin
      if (Rst) begin
         r_word_cnt <= '0;
         r_row      <= '0;
      end else if (i_clear) begin
         r_word_cnt <= '0;
      end else if (i_accept) begin
         r_row      <= o_row;
         r_word_cnt <= w_row_full ? '0 : r_word_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/weight_ram_writer.sv
// Streams weight words into rows and issues one row-wide RAM write per row at row-aligned bases.
// Optional running checksum of accepted words: define WEIGHT_WRITER_CHECKSUM_EN.
module weight_ram_writer
   import weight_pkg::*;
#(
   parameter int unsigned CSUM_W = 16
) (
   input  logic                Clock,
   input  logic                Rst,
   input  logic                i_start,
   input  logic                i_in_valid,
   input  logic [WEIGHT_W-1:0] i_in_data,
   output logic                o_in_ready,
   output logic                o_wr_en,
   output logic [WADDR_W-1:0]  o_wr_addr,
   output logic [ROW_BITS-1:0] o_wr_data,
   output logic                o_busy,
   output logic                o_done,
   output logic [CSUM_W-1:0]   o_checksum
);

   writer_state_e        r_state, w_state;
   logic                 r_in_ready, w_in_ready;
   logic                 r_wr_en, w_wr_en;
   logic [WADDR_W-1:0]   r_wr_addr, w_wr_addr;
   logic [ROW_BITS-1:0]  r_wr_data, w_wr_data;
   logic                 r_busy, w_busy;
   logic                 r_done, w_done;
   logic [ROW_IDX_W-1:0] r_row_idx, w_row_idx;

   logic                 w_accept;
   logic                 w_start_acc;
   logic                 w_last;
   logic [ROW_BITS-1:0]  w_row;

   // r_in_ready is high exactly in FILL, so it alone qualifies the handshake.
   assign w_accept    = i_in_valid && r_in_ready;
   assign w_start_acc = (r_state == IDLE) && i_start;

   weight_row_packer u_packer (
      .Clock    (Clock),
      .Rst      (Rst),
      .i_clear  (w_start_acc),
      .i_accept (w_accept),
      .i_word   (i_in_data),
      .o_last   (w_last),
      .o_row    (w_row)
   );

   always_comb begin
      w_state    = r_state;
      w_in_ready = r_in_ready;
      w_wr_en    = 1'b0;
      w_wr_addr  = r_wr_addr;
      w_wr_data  = r_wr_data;
      w_busy     = r_busy;
      w_done     = 1'b0;
      w_row_idx  = r_row_idx;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state    = FILL;
               w_in_ready = 1'b1;
               w_busy     = 1'b1;
               w_row_idx  = '0;
            end
         end
         FILL: begin
            if (w_last) begin
               w_state    = WRITE;
               w_in_ready = 1'b0;
               w_wr_en    = 1'b1;
               w_wr_addr  = row_base(r_row_idx);
               w_wr_data  = w_row;
            end
         end
         WRITE: begin
            if (r_row_idx == ROW_IDX_W'(NUM_ROWS - 1)) begin
               w_state = DONE;
               w_done  = 1'b1;
            end else begin
               w_state    = FILL;
               w_in_ready = 1'b1;
               w_row_idx  = r_row_idx + ROW_IDX_W'(1);
            end
         end
         DONE: begin
            w_state = IDLE;
            w_busy  = 1'b0;
         end
         default: begin
            w_state    = IDLE;
            w_in_ready = 1'b0;
            w_busy     = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Rst) begin
         r_state    <= IDLE;
         r_in_ready <= 1'b0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_row_idx  <= '0;
      end else begin
         r_state    <= w_state;
         r_in_ready <= w_in_ready;
         r_wr_en    <= w_wr_en;
         r_wr_addr  <= w_wr_addr;
         r_wr_data  <= w_wr_data;
         r_busy     <= w_busy;
         r_done     <= w_done;
         r_row_idx  <= w_row_idx;
      end
   end

   assign o_in_ready = r_in_ready;
   assign o_wr_en    = r_wr_en;
   assign o_wr_addr  = r_wr_addr;
   assign o_wr_data  = r_wr_data;
   assign o_busy     = r_busy;
   assign o_done     = r_done;

`ifdef WEIGHT_WRITER_CHECKSUM_EN
   logic [CSUM_W-1:0] r_checksum;

   always_ff @(posedge Clock) begin
      if (Rst || w_start_acc) begin
         r_checksum <= '0;
      end else if (w_accept) begin
         r_checksum <= r_checksum + CSUM_W'(i_in_data);
      end
   end

   assign o_checksum = r_checksum;
`else
   assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_weight_ram_writer.sv
// Bench for weight_ram_writer: scenario table plus hand-written restart and start-while-busy
// sequences, checked against a word-list model of the RAM contents.
module tb_weight_ram_writer;

   logic         Clock = 1'b0;
   logic         Rst;
   logic         i_start;
   logic         i_in_valid;
   logic [9:0]   i_in_data;
   logic         o_in_ready;
   logic         o_wr_en;
   logic [6:0]   o_wr_addr;
   logic [99:0]  o_wr_data;
   logic         o_busy;
   logic         o_done;
   logic [15:0]  o_checksum;

   weight_ram_writer dut (
      .Clock      (Clock),
      .Rst        (Rst),
      .i_start    (i_start),
      .i_in_valid (i_in_valid),
      .i_in_data  (i_in_data),
      .o_in_ready (o_in_ready),
      .o_wr_en    (o_wr_en),
      .o_wr_addr  (o_wr_addr),
      .o_wr_data  (o_wr_data),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_checksum (o_checksum)
   );

   always #5 Clock = ~Clock;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int start_cyc;
   int done_cnt;
   int done_cyc;

   logic [9:0]  model_q[$];
   int          exp_wcyc_q[$];
   logic [6:0]  wr_addr_q[$];
   int          wr_cyc_q[$];
   logic [99:0] wr_data_q[$];

   typedef struct {
      int gap;        // 0 continuous, 1 alternate, 2 random
      int dmode;      // 0 index, 1 random, 2 all ones
      int nwords;
      int rst_after;  // 0: no reset mid-sequence
      int exp_writes;
      int exp_dones;
      int exp_csum;   // -1: derive from accepted words
   } vec_t;

   vec_t tbl[6];

   always @(posedge Clock) cyc <= cyc + 1;

   always @(negedge Clock) begin
      if (o_wr_en) begin
         wr_addr_q.push_back(o_wr_addr);
         wr_cyc_q.push_back(cyc);
         wr_data_q.push_back(o_wr_data);
      end
      if (o_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [9:0] next_word(input int dmode, input int idx);
      logic [31:0] v;
      v = idx;
      case (dmode)
         0:       return v[9:0];
         1:       return 10'($urandom_range(0, 1023));
         default: return 10'h3FF;
      endcase
   endfunction

   task automatic clear_model();
      model_q.delete();
      exp_wcyc_q.delete();
      wr_addr_q.delete();
      wr_cyc_q.delete();
      wr_data_q.delete();
      done_cnt = 0;
      done_cyc = 0;
   endtask

   task automatic apply_reset();
      Rst        = 1'b1;
      i_start    = 1'b0;
      i_in_valid = 1'b1;
      i_in_data  = 10'($urandom_range(0, 1023));
      for (int i = 0; i < 3; i++) begin
         @(posedge Clock);
         #1;
         check("rst_in_ready", o_in_ready, 0);
         check("rst_wr_en", o_wr_en, 0);
         check("rst_wr_addr", o_wr_addr, 0);
         check("rst_wr_data", o_wr_data, 0);
         check("rst_busy", o_busy, 0);
         check("rst_done", o_done, 0);
         check("rst_checksum", o_checksum, 0);
      end
      Rst        = 1'b0;
      i_in_valid = 1'b0;
   endtask

   task automatic do_start();
      i_start = 1'b1;
      @(negedge Clock);
      start_cyc = cyc + 1;
      @(posedge Clock);
      #1;
      i_start = 1'b0;
      check("start_busy", o_busy, 1);
   endtask

   // Holds each word until it is taken; the model records exactly the transferred words.
   task automatic feed(input int n, input int gap, input int dmode, input int rst_after);
      int         sent = 0;
      int         guard = 0;
      logic       v;
      logic       acc;
      logic [9:0] w;
      w = next_word(dmode, model_q.size());
      while (sent < n && guard < 3000) begin
         case (gap)
            0:       v = 1'b1;
            1:       v = (guard % 2) == 0;
            default: v = 1'($urandom_range(0, 1));
         endcase
         i_in_valid = v;
         i_in_data  = w;
         @(negedge Clock);
         acc = v && o_in_ready;
         if (acc) begin
            model_q.push_back(w);
            sent++;
            if (model_q.size() % 10 == 0) exp_wcyc_q.push_back(cyc + 1);
            w = next_word(dmode, model_q.size());
         end
         @(posedge Clock);
         #1;
         guard++;
         if (rst_after > 0 && sent == rst_after) break;
      end
      i_in_valid = 1'b0;
      if (guard >= 3000) check("feed_timeout", 0, 1);
   endtask

   task automatic wait_done(input int exp_dones);
      int t = 0;
      while (done_cnt < exp_dones && t < 300) begin
         @(posedge Clock);
         #1;
         t++;
      end
      repeat (3) @(posedge Clock);
      #1;
   endtask

   task automatic evaluate(input string tag, input int exp_writes, input int exp_dones,
                           input int exp_csum, input bit chk_lat);
      logic [99:0] er;
      int          sum;
      check({tag, "_writes"}, wr_addr_q.size(), exp_writes);
      for (int i = 0; i < exp_writes && i < wr_addr_q.size(); i++) begin
         check({tag, "_addr"}, wr_addr_q[i], i * 10);
         if (i < exp_wcyc_q.size()) check({tag, "_wr_latency"}, wr_cyc_q[i], exp_wcyc_q[i]);
         for (int k = 0; k < 10; k++) er[k*10 +: 10] = model_q[i*10 + k];
         check({tag, "_row"}, wr_data_q[i], er);
      end
      check({tag, "_dones"}, done_cnt, exp_dones);
      if (exp_dones > 0) begin
         if (wr_cyc_q.size() > 0) check({tag, "_done_after_write"}, done_cyc, wr_cyc_q[$] + 1);
         if (chk_lat) check({tag, "_done_cycle"}, done_cyc - start_cyc, 110);
         check({tag, "_busy_end"}, o_busy, 0);
         sum = 0;
         foreach (model_q[j]) sum += int'(model_q[j]);
`ifdef WEIGHT_WRITER_CHECKSUM_EN
         if (exp_csum >= 0) sum = exp_csum;
         check({tag, "_checksum"}, o_checksum, sum % 65536);
`else
         check({tag, "_checksum"}, o_checksum, exp_csum * 0);
`endif
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{gap: 0, dmode: 0, nwords: 100, rst_after: 0, exp_writes: 10, exp_dones: 1,
                 exp_csum: -1};
      tbl[1] = '{gap: 1, dmode: 0, nwords: 100, rst_after: 0, exp_writes: 10, exp_dones: 1,
                 exp_csum: -1};
      tbl[2] = '{gap: 0, dmode: 1, nwords: 100, rst_after: 0, exp_writes: 10, exp_dones: 1,
                 exp_csum: -1};
      tbl[3] = '{gap: 2, dmode: 1, nwords: 100, rst_after: 0, exp_writes: 10, exp_dones: 1,
                 exp_csum: -1};
      tbl[4] = '{gap: 0, dmode: 2, nwords: 100, rst_after: 0, exp_writes: 10, exp_dones: 1,
                 exp_csum: 36764};
      tbl[5] = '{gap: 0, dmode: 1, nwords: 100, rst_after: 25, exp_writes: 2, exp_dones: 0,
                 exp_csum: -1};

      for (int s = 0; s < 6; s++) begin
         apply_reset();
         clear_model();
         do_start();
         feed(tbl[s].nwords, tbl[s].gap, tbl[s].dmode, tbl[s].rst_after);
         if (tbl[s].rst_after > 0) begin
            Rst = 1'b1;
            @(posedge Clock);
            #1;
            check("midrst_busy", o_busy, 0);
            check("midrst_in_ready", o_in_ready, 0);
            check("midrst_wr_en", o_wr_en, 0);
            Rst = 1'b0;
            repeat (3) @(posedge Clock);
            #1;
            check("midrst_idle_ready", o_in_ready, 0);
         end else begin
            wait_done(tbl[s].exp_dones);
         end
         evaluate($sformatf("vec%0d", s), tbl[s].exp_writes, tbl[s].exp_dones,
                  tbl[s].exp_csum, tbl[s].gap == 0);
      end

      // Restart after the mid-sequence reset must begin again at address 0.
      clear_model();
      do_start();
      feed(100, 0, 1, 0);
      wait_done(1);
      evaluate("restart", 10, 1, -1, 1'b1);

      // Start while busy at row 4 must be ignored.
      apply_reset();
      clear_model();
      do_start();
      feed(45, 0, 0, 0);
      i_start = 1'b1;
      @(posedge Clock);
      #1;
      i_start = 1'b0;
      check("ignstart_busy", o_busy, 1);
      check("ignstart_rows_so_far", wr_addr_q.size(), 4);
      feed(55, 0, 0, 0);
      wait_done(1);
      evaluate("ignstart", 10, 1, -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
